// File: rtl/rtc_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_ctrl_pkg
//  Description : Shared constants, state encoding and bus-level helper for the
//                multiplexed-AD RTC bus controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_bus_ctrl_pkg;

    localparam int PHASE_CYCLES_DEFAULT = 8;
    localparam int AD_W                 = 8;

    // Controller states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_GAP = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_DATA_GAP = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // Everything the controller drives onto the RTC pins
    typedef struct packed {
        logic            cs_n;
        logic            rd_n;
        logic            wr_n;
        logic            a_d_n;
        logic            ad_oe;
        logic [AD_W-1:0] ad_out;
    } bus_t;

    localparam bus_t BUS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                                  a_d_n: 1'b1, ad_oe: 1'b0, ad_out: '0};

    // Pin levels that belong to a given state; the caller registers the result
    // so the pins never see a combinational path from the inputs.
    function automatic bus_t bus_levels(input logic [2:0]      st,
                                        input logic            wr,
                                        input logic [AD_W-1:0] a,
                                        input logic [AD_W-1:0] d);
        bus_t b;
        b = BUS_IDLE;
        case (st)
            ST_ADDR: begin
                b.cs_n   = 1'b0;
                b.wr_n   = 1'b0;
                b.a_d_n  = 1'b0;
                b.ad_oe  = 1'b1;
                b.ad_out = a;
            end
            ST_ADDR_GAP: begin
                // strobes released, address kept on the bus as hold time
                b.a_d_n  = 1'b0;
                b.ad_oe  = 1'b1;
                b.ad_out = a;
            end
            ST_DATA: begin
                b.cs_n = 1'b0;
                if (wr) begin
                    b.wr_n   = 1'b0;
                    b.ad_oe  = 1'b1;
                    b.ad_out = d;
                end else begin
                    b.rd_n = 1'b0;
                end
            end
            ST_DATA_GAP: begin
                // write data held after the strobe; reads leave the bus released
                if (wr) begin
                    b.ad_oe  = 1'b1;
                    b.ad_out = d;
                end
            end
            default: b = BUS_IDLE;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_phase_timer
//  Description : Loadable down-counter that flags the last cycle of a bus phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    // Reload on phase entry, otherwise count down and rest at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rtc_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_ctrl
//  Description : Sequencer for a multiplexed address/data RTC bus: address
//                phase, address hold, data phase, data hold, done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_ctrl
    import rtc_bus_ctrl_pkg::*;
#(
    parameter int PHASE_CYCLES = PHASE_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            we,
    input  logic [AD_W-1:0] addr,
    input  logic [AD_W-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [AD_W-1:0] rdata,
    output logic            cs_n,
    output logic            rd_n,
    output logic            wr_n,
    output logic            a_d_n,
    output logic [AD_W-1:0] ad_out,
    output logic            ad_oe,
    input  logic [AD_W-1:0] ad_in
);

    // The timer counts PHASE_CYCLES-1 .. 0, so expiry marks the last cycle
    localparam logic [7:0] PHASE_LOAD = 8'(PHASE_CYCLES - 1);

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic            r_we;
    logic [AD_W-1:0] r_addr;
    logic [AD_W-1:0] r_wdata;
    logic            w_accept;
    logic            w_expired;
    logic            w_load;
    logic            w_capture;
    logic            w_we_nxt;
    logic [AD_W-1:0] w_addr_nxt;
    logic [AD_W-1:0] w_wdata_nxt;
    bus_t            r_bus;

    assign w_accept = (r_state == ST_IDLE) && req;

    rtc_phase_timer #(
        .WIDTH    (8)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (PHASE_LOAD),
        .expired  (w_expired)
    );

    // Next-state decode: every timed phase advances when its timer expires
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (req)       w_next_state = ST_ADDR;
            ST_ADDR:     if (w_expired) w_next_state = ST_ADDR_GAP;
            ST_ADDR_GAP: if (w_expired) w_next_state = ST_DATA;
            ST_DATA:     if (w_expired) w_next_state = ST_DATA_GAP;
            ST_DATA_GAP: if (w_expired) w_next_state = ST_DONE;
            ST_DONE:                    w_next_state = ST_IDLE;
            default:                    w_next_state = ST_IDLE;
        endcase
    end

    assign w_load = (w_next_state != r_state) &&
                    (w_next_state inside {ST_ADDR, ST_ADDR_GAP, ST_DATA, ST_DATA_GAP});

    assign w_capture = (r_state == ST_DATA) && w_expired && !r_we;

    // Values the transaction registers will hold after this edge, so the
    // registered pins already show the new address in the first ADDR cycle
    assign w_we_nxt    = w_accept ? we    : r_we;
    assign w_addr_nxt  = w_accept ? addr  : r_addr;
    assign w_wdata_nxt = w_accept ? wdata : r_wdata;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Transaction latch, loaded only when a request is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    // Registered status and pin levels, decoded from the upcoming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            r_bus <= BUS_IDLE;
        end else begin
            busy  <= (w_next_state != ST_IDLE);
            done  <= (w_next_state == ST_DONE);
            r_bus <= bus_levels(w_next_state, w_we_nxt, w_addr_nxt, w_wdata_nxt);
        end
    end

    // Read data sampled on the final cycle of the read strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (w_capture) begin
            rdata <= ad_in;
        end
    end

    assign cs_n   = r_bus.cs_n;
    assign rd_n   = r_bus.rd_n;
    assign wr_n   = r_bus.wr_n;
    assign a_d_n  = r_bus.a_d_n;
    assign ad_oe  = r_bus.ad_oe;
    assign ad_out = r_bus.ad_out;

endmodule
`default_nettype wire
